// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: command opcodes, ALU op codes,
// FSM state encoding and {N,V,Z,C} flag bit positions.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADC = 4'd0;
  localparam logic [3:0] OP_SBC = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_EOR = 4'd3;
  localparam logic [3:0] OP_ORA = 4'd4;
  localparam logic [3:0] OP_LSR = 4'd5;
  localparam logic [3:0] OP_ROR = 4'd6;
  localparam logic [3:0] OP_CMP = 4'd7;
  localparam logic [3:0] OP_ASL = 4'd8;
  localparam logic [3:0] OP_ROL = 4'd9;
  localparam logic [3:0] OP_CLC = 4'd10;
  localparam logic [3:0] OP_SEC = 4'd11;

  typedef enum logic [2:0] {
    ALU_NONE = 3'd0,
    ALU_SUM  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_EOR  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_SR   = 3'd5,
    ALU_ROR  = 3'd6
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BYTE0 = 2'd1,
    ST_BYTE1 = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  // Right shifts walk the word from the top byte down so the carry falls into bit 7 below.
  function automatic logic is_hi_first(input logic [3:0] op);
    return (op == OP_LSR) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/alu8.sv
// 8-bit ALU datapath: add with optional B inversion, logic ops, right shift/rotate.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// SR and ROR both shift carry_in into bit 7; the sequencer chooses what that carry is.
module alu8
  import alu_seq_pkg::*;
(
  input  alu_op_e    op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       inv,
  input  logic       cin,
  output logic [7:0] y,
  output logic       cout,
  output logic       v
);

  logic [7:0] bb;
  logic [8:0] sum9;

  always_comb begin
    bb   = inv ? ~b : b;
    sum9 = {1'b0, a} + {1'b0, bb} + {8'h00, cin};
    y    = 8'h00;
    cout = 1'b0;
    v    = 1'b0;
    case (op)
      ALU_SUM: begin
        y    = sum9[7:0];
        cout = sum9[8];
        v    = (a[7] == bb[7]) && (sum9[7] != a[7]);
      end
      ALU_AND: y = a & b;
      ALU_EOR: y = a ^ b;
      ALU_OR:  y = a | b;
      ALU_SR, ALU_ROR: begin
        y    = {cin, a[7:1]};
        cout = a[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_flag_update.sv
// Next-value merge of the {N,V,Z,C} status flags from the final byte of a command.
// Latency: combinational. Backpressure: none, the sequencer decides when to commit.
module alu_flag_update
  import alu_seq_pkg::*;
(
  input  logic [3:0] op,
  input  logic       wide,
  input  logic [7:0] res_lo,
  input  logic [7:0] res_hi,
  input  logic       carry_out,
  input  logic       v_in,
  input  logic [3:0] flags_cur,
  output logic [3:0] flags_nxt
);

  logic n_res;
  logic z_res;

  always_comb begin
    n_res     = wide ? res_hi[7] : res_lo[7];
    z_res     = (res_lo == 8'h00) && (!wide || (res_hi == 8'h00));
    flags_nxt = flags_cur;
    case (op)
      OP_ADC, OP_SBC: begin
        flags_nxt[FLAG_N] = n_res;
        flags_nxt[FLAG_V] = v_in;
        flags_nxt[FLAG_Z] = z_res;
        flags_nxt[FLAG_C] = carry_out;
      end
      OP_CMP, OP_LSR, OP_ROR, OP_ASL, OP_ROL: begin
        flags_nxt[FLAG_N] = n_res;
        flags_nxt[FLAG_Z] = z_res;
        flags_nxt[FLAG_C] = carry_out;
      end
      OP_AND, OP_EOR, OP_ORA: begin
        flags_nxt[FLAG_N] = n_res;
        flags_nxt[FLAG_Z] = z_res;
      end
      OP_CLC: flags_nxt[FLAG_C] = 1'b0;
      OP_SEC: flags_nxt[FLAG_C] = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Byte-serial ALU controller owning the {N,V,Z,C} flags; ALU_SEQ_PERF_EN adds perf counters.
// Latency: response valid 2 cycles after accept (narrow), 3 (wide).
// Backpressure: one command in flight; cmd_ready low until the response is taken.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int OP_W   = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic              cmd_wide,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
`ifdef ALU_SEQ_PERF_EN
  output logic [15:0]       perf_cmds,
  output logic [15:0]       perf_busy,
`endif
  output logic [3:0]        flags
);

  state_e            state;
  logic [OP_W-1:0]   op_q;
  logic              wide_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [7:0]        res_lo_q, res_hi_q;
  logic              carry_q;

  logic              first, on_hi, last;
  logic [7:0]        a_byte, b_byte;
  alu_op_e           alu_op;
  logic [7:0]        alu_a, alu_b, alu_y;
  logic              alu_inv, alu_cin, alu_cout, alu_v;
  logic [7:0]        fin_lo, fin_hi;
  logic [3:0]        flags_nxt;
  logic [DATA_W-1:0] a_masked, data_nxt;
  logic              err_nxt;

  assign cmd_ready = !rst && (state == ST_IDLE);

  assign first  = (state == ST_BYTE0);
  assign on_hi  = wide_q && ((state == ST_BYTE1) ^ is_hi_first(op_q));
  assign last   = (state == ST_BYTE1) || !wide_q;
  assign a_byte = on_hi ? a_q[15:8] : a_q[7:0];
  assign b_byte = on_hi ? b_q[15:8] : b_q[7:0];

  // First byte takes the opcode's own carry-in; the second chains the first's carry-out.
  always_comb begin
    alu_op  = ALU_NONE;
    alu_inv = 1'b0;
    alu_a   = a_byte;
    alu_b   = b_byte;
    alu_cin = first ? 1'b0 : carry_q;
    case (op_q)
      OP_ADC: begin
        alu_op = ALU_SUM;
        if (first) alu_cin = flags[FLAG_C];
      end
      OP_SBC: begin
        alu_op  = ALU_SUM;
        alu_inv = 1'b1;
        if (first) alu_cin = flags[FLAG_C];
      end
      OP_AND: alu_op = ALU_AND;
      OP_EOR: alu_op = ALU_EOR;
      OP_ORA: alu_op = ALU_OR;
      OP_LSR: alu_op = ALU_SR;
      OP_ROR: begin
        alu_op = ALU_ROR;
        if (first) alu_cin = flags[FLAG_C];
      end
      OP_CMP: begin
        alu_op  = ALU_SUM;
        alu_inv = 1'b1;
        if (first) alu_cin = 1'b1;
      end
      OP_ASL: begin
        alu_op = ALU_SUM;
        alu_b  = a_byte;
      end
      OP_ROL: begin
        alu_op = ALU_SUM;
        alu_b  = a_byte;
        if (first) alu_cin = flags[FLAG_C];
      end
      default: ;
    endcase
  end

  alu8 u_alu (
    .op   (alu_op),
    .a    (alu_a),
    .b    (alu_b),
    .inv  (alu_inv),
    .cin  (alu_cin),
    .y    (alu_y),
    .cout (alu_cout),
    .v    (alu_v)
  );

  assign fin_lo = on_hi ? res_lo_q : alu_y;
  assign fin_hi = !wide_q ? 8'h00 : (on_hi ? alu_y : res_hi_q);

  alu_flag_update u_flags (
    .op        (op_q),
    .wide      (wide_q),
    .res_lo    (fin_lo),
    .res_hi    (fin_hi),
    .carry_out (alu_cout),
    .v_in      (alu_v),
    .flags_cur (flags),
    .flags_nxt (flags_nxt)
  );

  assign a_masked = wide_q ? a_q : {8'h00, a_q[7:0]};
  assign err_nxt  = (op_q >= 4'd12);

  always_comb begin
    data_nxt = {fin_hi, fin_lo};
    if (op_q == OP_CMP || op_q == OP_CLC || op_q == OP_SEC || err_nxt)
      data_nxt = a_masked;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      flags     <= 4'b0000;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      op_q      <= '0;
      wide_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      res_lo_q  <= 8'h00;
      res_hi_q  <= 8'h00;
      carry_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            wide_q <= cmd_wide;
            a_q    <= cmd_a;
            b_q    <= cmd_b;
            state  <= ST_BYTE0;
          end
        end
        ST_BYTE0, ST_BYTE1: begin
          if (on_hi) res_hi_q <= alu_y;
          else       res_lo_q <= alu_y;
          carry_q <= alu_cout;
          if (last) begin
            flags     <= flags_nxt;
            rsp_data  <= data_nxt;
            rsp_err   <= err_nxt;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            state <= ST_BYTE1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cmds <= 16'h0000;
      perf_busy <= 16'h0000;
    end else begin
      if (cmd_valid && cmd_ready && perf_cmds != 16'hFFFF) perf_cmds <= perf_cmds + 16'd1;
      if (state != ST_IDLE && perf_busy != 16'hFFFF) perf_busy <= perf_busy + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a vector table run in order (flags carry
// across entries), then backpressure, reset-in-flight and recovery sequences.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_wide;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_a, cmd_b;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [15:0] rsp_data;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  op;
    logic        wide;
    logic [15:0] a;
    logic [15:0] b;
    logic        chk_data;
    logic [15:0] data;
    logic        err;
    logic [3:0]  flags;
  } vec_t;

  typedef struct {
    logic        chk_data;
    logic [15:0] data;
    logic        err;
    logic [3:0]  flags;
  } exp_t;

  localparam int NV = 18;
  vec_t vecs[NV];
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_wide  (cmd_wide),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .flags     (flags)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present a command and hold it until the edge that accepts it; returns at accept edge + #1.
  task automatic issue(input logic [3:0] op, input logic wide, input logic [15:0] a,
                       input logic [15:0] b);
    int n;
    @(negedge clk);
    cmd_op = op; cmd_wide = wide; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept", cmd_ready, 1'b1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic push_exp(input logic chk_data, input logic [15:0] data, input logic err,
                          input logic [3:0] f);
    exp_t e;
    e.chk_data = chk_data; e.data = data; e.err = err; e.flags = f;
    sb.push_back(e);
  endtask

  // Wait for the response, compare against the scoreboard head, optionally stall it.
  task automatic collect(input int exp_lat, input int hold);
    int   cyc;
    exp_t e;
    cyc = 1;
    while (!rsp_valid && cyc < 20) begin
      @(posedge clk);
      #1 cyc++;
    end
    chk("latency", cyc, exp_lat);
    if (!rsp_valid) return;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: response with no expected entry");
      return;
    end
    e = sb.pop_front();
    if (e.chk_data) chk("rsp_data", rsp_data, e.data);
    chk("rsp_err", rsp_err, e.err);
    chk("flags", flags, e.flags);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_data", rsp_data, e.data);
      chk("hold_flags", flags, e.flags);
      chk("hold_cmd_ready", cmd_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rsp_drop", rsp_valid, 1'b0);
    chk("idle_ready", cmd_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    //          op     wide  a         b         chk   data      err   NVZC
    vecs[0]  = '{4'd0,  1'b0, 16'h0050, 16'h0050, 1'b1, 16'h00A0, 1'b0, 4'b1100};
    vecs[1]  = '{4'd11, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'b1101};
    vecs[2]  = '{4'd1,  1'b1, 16'h1000, 16'h0001, 1'b1, 16'h0FFF, 1'b0, 4'b0001};
    vecs[3]  = '{4'd5,  1'b1, 16'h0101, 16'h0000, 1'b1, 16'h0080, 1'b0, 4'b0001};
    vecs[4]  = '{4'd6,  1'b1, 16'h0000, 16'h0000, 1'b1, 16'h8000, 1'b0, 4'b1000};
    vecs[5]  = '{4'd0,  1'b0, 16'h0050, 16'h0050, 1'b1, 16'h00A0, 1'b0, 4'b1100};
    vecs[6]  = '{4'd7,  1'b0, 16'h0040, 16'h0040, 1'b1, 16'h0040, 1'b0, 4'b0111};
    vecs[7]  = '{4'd11, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'b0111};
    vecs[8]  = '{4'd2,  1'b0, 16'h000F, 16'h00F0, 1'b1, 16'h0000, 1'b0, 4'b0111};
    vecs[9]  = '{4'd13, 1'b1, 16'h1234, 16'h5678, 1'b1, 16'h1234, 1'b1, 4'b0111};
    vecs[10] = '{4'd8,  1'b1, 16'h8081, 16'h0000, 1'b1, 16'h0102, 1'b0, 4'b0101};
    vecs[11] = '{4'd9,  1'b0, 16'hFF80, 16'h0000, 1'b1, 16'h0001, 1'b0, 4'b0101};
    vecs[12] = '{4'd3,  1'b1, 16'hFF00, 16'h0F0F, 1'b1, 16'hF00F, 1'b0, 4'b1101};
    vecs[13] = '{4'd4,  1'b0, 16'hAB00, 16'h1200, 1'b1, 16'h0000, 1'b0, 4'b0111};
    vecs[14] = '{4'd10, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'b0110};
    vecs[15] = '{4'd0,  1'b1, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 1'b0, 4'b1100};
    vecs[16] = '{4'd0,  1'b1, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b0, 4'b0011};
    vecs[17] = '{4'd5,  1'b0, 16'h0301, 16'h0000, 1'b1, 16'h0000, 1'b0, 4'b0011};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_wide = 1'b0;
    cmd_a = 16'h0000; cmd_b = 16'h0000; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_flags", flags, 4'b0000);
    chk("rst_rsp_data", rsp_data, 16'h0000);
    chk("rst_rsp_err", rsp_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_ready", cmd_ready, 1'b1);

    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].op, vecs[i].wide, vecs[i].a, vecs[i].b);
      push_exp(vecs[i].chk_data, vecs[i].data, vecs[i].err, vecs[i].flags);
      collect(vecs[i].wide ? 3 : 2, 0);
    end

    // Stalled consumer: C=1 going in, 0xFF+0x01+1 = 0x101.
    rsp_ready = 1'b0;
    issue(4'd0, 1'b0, 16'h00FF, 16'h0001);
    push_exp(1'b1, 16'h0001, 1'b0, 4'b0001);
    collect(2, 5);

    // Reset while a wide ADC sits in BYTE1: command vanishes, flags clear.
    issue(4'd0, 1'b1, 16'h1111, 16'h2222);
    @(posedge clk);
    #1 rst = 1'b1;
    chk("mid_rst_ready", cmd_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("mid_rst_valid", rsp_valid, 1'b0);
    chk("mid_rst_flags", flags, 4'b0000);
    chk("mid_rst_data", rsp_data, 16'h0000);
    rst = 1'b0;
    #1 chk("after_rst_ready", cmd_ready, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk("dropped_no_rsp", rsp_valid, 1'b0);
    end

    issue(4'd0, 1'b0, 16'h0005, 16'h0003);
    push_exp(1'b1, 16'h0008, 1'b0, 4'b0000);
    collect(2, 0);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
